// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_sdp_sync memory block.
// Contents: clear-sequencer state enum, byte-merge function, per-byte parity function.
// Helpers work on a fixed maximum width. Callers zero-extend into them and truncate the result.
package ram_pkg;

    localparam int unsigned MAX_DATA_W = 256;
    localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Replace the bytes of old_word selected by be with the matching bytes of new_word
    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int unsigned i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Even-parity bit per byte: the XOR of the byte's bits
    function automatic logic [MAX_BE_W-1:0] byte_parity(
        input logic [MAX_DATA_W-1:0] word
    );
        logic [MAX_BE_W-1:0] par;
        for (int unsigned i = 0; i < MAX_BE_W; i++) begin
            par[i] = ^word[8*i +: 8];
        end
        return par;
    endfunction

endpackage

// File: rtl/ram_sdp_sync_if.sv
// Request/response bundle for ram_sdp_sync.
// master: drives cs, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr (plus par_inject).
//         It receives rd_data, rd_valid, init_busy, addr_err (plus rd_par_err).
// slave : the memory side of the same signals.
// RAM_PARITY_EN adds par_inject and rd_par_err.
interface ram_sdp_sync_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) ();

    localparam int unsigned BE_W = DATA_W / 8;

    logic              cs;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              init_busy;
    logic              addr_err;
`ifdef RAM_PARITY_EN
    logic              par_inject;
    logic              rd_par_err;

    modport master (
        output cs, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, par_inject,
        input  rd_data, rd_valid, init_busy, addr_err, rd_par_err
    );
    modport slave (
        input  cs, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, par_inject,
        output rd_data, rd_valid, init_busy, addr_err, rd_par_err
    );
`else
    modport master (
        output cs, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, init_busy, addr_err
    );
    modport slave (
        input  cs, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, init_busy, addr_err
    );
`endif

endinterface

// File: rtl/ram_init_seq.sv
// Post-reset clear sequencer. It walks every address once, then parks in READY until the next reset.
// Ports: clk, rst_n (async, active-low).
//   init_busy : high from reset until the last clear write has been issued.
//   init_we   : write strobe for the clear data.
//   init_addr : address being cleared.
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              busy_nxt;

    // State, counter and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            cnt       <= '0;
            init_busy <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            init_busy <= busy_nxt;
        end
    end

    // Next state: one clear write per cycle, then leave INIT after the last address
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = init_busy;
        case (state)
            ST_INIT: begin
                cnt_nxt = cnt + ADDR_W'(1);
                if (cnt == LAST_ADDR) begin
                    state_nxt = ST_READY;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                end
            end
            ST_READY: begin
                state_nxt = ST_READY;
            end
            default: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
                busy_nxt  = 1'b1;
            end
        endcase
    end

    assign init_we   = init_busy;
    assign init_addr = cnt;

endmodule

// File: rtl/ram_sdp_sync.sv
// Simple-dual-port synchronous RAM with byte enables, write-first collision bypass,
// a read latency of 1 or 2 cycles, and a post-reset clear sequence.
// Ports: clk, rst_n (async, active-low), bus (ram_sdp_sync_if.slave).
//   bus carries cs, the write port, the read port, rd_data/rd_valid, init_busy and addr_err.
// Optional feature: define RAM_PARITY_EN to enable per-byte even parity.
//   It adds bus.par_inject and bus.rd_par_err.
module ram_sdp_sync
    import ram_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 10,
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       DEPTH    = 1024,
    parameter int unsigned       RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_sdp_sync_if.slave bus
);

    localparam int unsigned     BE_W    = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic              init_busy;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;

    ram_init_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_init_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_busy (init_busy),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_in_range_c, rd_in_range_c;
    logic              wr_req_c, rd_req_c, wr_acc_c, rd_acc_c;
    logic              addr_err_c, collide_c;
    logic [DATA_W-1:0] mem_rd_c, rd_word_c;

    // Request qualification: cs gates both ports, nothing is accepted while clearing
    always_comb begin
        wr_in_range_c = {1'b0, bus.wr_addr} < DEPTH_L;
        rd_in_range_c = {1'b0, bus.rd_addr} < DEPTH_L;
        wr_req_c      = bus.cs & bus.wr_en & ~init_busy;
        rd_req_c      = bus.cs & bus.rd_en & ~init_busy;
        wr_acc_c      = wr_req_c & wr_in_range_c;
        rd_acc_c      = rd_req_c & rd_in_range_c;
        addr_err_c    = (wr_req_c & ~wr_in_range_c) | (rd_req_c & ~rd_in_range_c);
        collide_c     = wr_acc_c & rd_acc_c & (bus.wr_addr == bus.rd_addr);
    end

    // Read word with write-first bypass on a same-address collision
    always_comb begin
        mem_rd_c  = mem[bus.rd_addr];
        rd_word_c = mem_rd_c;
        if (collide_c) begin
            rd_word_c = DATA_W'(be_merge(MAX_DATA_W'(mem_rd_c), MAX_DATA_W'(bus.wr_data),
                                         MAX_BE_W'(bus.wr_be)));
        end
    end

    // Array write: clear sequencer, or the byte-enabled user write
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= INIT_VAL;
        end else if (wr_acc_c) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (bus.wr_be[b]) begin
                    mem[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
                end
            end
        end
    end

    logic              s1_valid;
    logic              s1_err;
    logic [DATA_W-1:0] s1_data;

    // Read stage 1. The data register only moves on a valid read, so it holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_req_c;
            s1_err   <= addr_err_c;
            if (rd_req_c) begin
                s1_data <= rd_in_range_c ? rd_word_c : '0;
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic [BE_W-1:0] par_mem [DEPTH];
    logic [BE_W-1:0] wr_par_c, par_word_c, rd_calc_par_c;
    logic            s1_par_err;

    // Parity of the write data. par_inject flips it so that the next read fails its check.
    always_comb begin
        wr_par_c      = BE_W'(byte_parity(MAX_DATA_W'(bus.wr_data))) ^ {BE_W{bus.par_inject}};
        par_word_c    = par_mem[bus.rd_addr];
        if (collide_c) begin
            par_word_c = (par_word_c & ~bus.wr_be) | (wr_par_c & bus.wr_be);
        end
        rd_calc_par_c = BE_W'(byte_parity(MAX_DATA_W'(rd_word_c)));
    end

    always_ff @(posedge clk) begin
        if (init_we) begin
            par_mem[init_addr] <= BE_W'(byte_parity(MAX_DATA_W'(INIT_VAL)));
        end else if (wr_acc_c) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (bus.wr_be[b]) begin
                    par_mem[bus.wr_addr][b] <= wr_par_c[b];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_par_err <= 1'b0;
        end else begin
            s1_par_err <= rd_acc_c & (|(par_word_c ^ rd_calc_par_c));
        end
    end
`endif

    // Optional second output register. The collision bypass is already resolved in stage 1.
    if (RD_LAT == 2) begin : g_lat2
        logic              s2_valid;
        logic              s2_err;
        logic [DATA_W-1:0] s2_data;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid <= 1'b0;
                s2_err   <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                s2_err   <= s1_err;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign bus.rd_valid = s2_valid;
        assign bus.addr_err = s2_err;
        assign bus.rd_data  = s2_data;
`ifdef RAM_PARITY_EN
        logic s2_par_err;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_par_err <= 1'b0;
            end else begin
                s2_par_err <= s1_par_err;
            end
        end
        assign bus.rd_par_err = s2_par_err;
`endif
    end else begin : g_lat1
        assign bus.rd_valid = s1_valid;
        assign bus.addr_err = s1_err;
        assign bus.rd_data  = s1_data;
`ifdef RAM_PARITY_EN
        assign bus.rd_par_err = s1_par_err;
`endif
    end

    assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_ram_sdp_sync.sv
// Testbench for ram_sdp_sync. It drives two instances with identical stimulus:
// one with RD_LAT=1 and one with RD_LAT=2. Both use DATA_W=32, DEPTH=20 and ADDR_W=5.
// Expected values come from directed vectors and from an array-based reference model.
module tb_ram_sdp_sync;

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int          DEP  = 20;
    localparam logic [31:0] INIT = 32'hC3C3_A5A5;

    logic clk;
    logic rst_n;

    ram_sdp_sync_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    ram_sdp_sync_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    ram_sdp_sync #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .RD_LAT(1), .INIT_VAL(INIT)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    ram_sdp_sync #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .RD_LAT(2), .INIT_VAL(INIT)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    assign bus_b.cs      = bus_a.cs;
    assign bus_b.wr_en   = bus_a.wr_en;
    assign bus_b.wr_addr = bus_a.wr_addr;
    assign bus_b.wr_data = bus_a.wr_data;
    assign bus_b.wr_be   = bus_a.wr_be;
    assign bus_b.rd_en   = bus_a.rd_en;
    assign bus_b.rd_addr = bus_a.rd_addr;
`ifdef RAM_PARITY_EN
    assign bus_b.par_inject = bus_a.par_inject;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] mdl_mem [32];
    int          init_left;
    logic [31:0] held_a;
    logic        pv_valid, pv_err;
    logic        r_valid, r_err;
    logic [31:0] r_data;

    typedef struct {
        logic        cs;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic [4:0]  ra;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Apply one cycle of requests, advance the model, and compare both instances after the edge
    task automatic step(input logic cs, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic re, input logic [4:0] ra);
        logic        b_valid, b_err;
        logic [31:0] b_data;
        bus_a.cs      = cs;
        bus_a.wr_en   = we;
        bus_a.wr_addr = wa;
        bus_a.wr_data = wd;
        bus_a.wr_be   = be;
        bus_a.rd_en   = re;
        bus_a.rd_addr = ra;
        r_valid = 1'b0;
        r_err   = 1'b0;
        r_data  = '0;
        if (init_left > 0) begin
            mdl_mem[5'(DEP - init_left)] = INIT;
            init_left--;
        end else if (cs) begin
            if (we) begin
                if (int'(wa) < DEP) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) mdl_mem[wa][8*b +: 8] = wd[8*b +: 8];
                    end
                end else begin
                    r_err = 1'b1;
                end
            end
            if (re) begin
                r_valid = 1'b1;
                if (int'(ra) < DEP) r_data = mdl_mem[ra];
                else                r_err  = 1'b1;
            end
        end
        b_valid = pv_valid;
        b_err   = pv_err;
        b_data  = held_a;
        if (r_valid) held_a = r_data;
        pv_valid = r_valid;
        pv_err   = r_err;
        @(posedge clk);
        #1;
        check("a_rd_valid",  32'(bus_a.rd_valid),  32'(r_valid));
        check("a_rd_data",   bus_a.rd_data,        held_a);
        check("a_addr_err",  32'(bus_a.addr_err),  32'(r_err));
        check("a_init_busy", 32'(bus_a.init_busy), 32'(init_left > 0));
        check("b_rd_valid",  32'(bus_b.rd_valid),  32'(b_valid));
        check("b_rd_data",   bus_b.rd_data,        b_data);
        check("b_addr_err",  32'(bus_b.addr_err),  32'(b_err));
        check("b_init_busy", 32'(bus_b.init_busy), 32'(init_left > 0));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    endtask

    // Assert reset mid-cycle, check that the outputs clear at once, and release on the next falling edge
    task automatic do_reset();
        bus_a.cs    = 1'b0;
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_a_rd_valid",  32'(bus_a.rd_valid),  32'h0);
        check("rst_a_rd_data",   bus_a.rd_data,        32'h0);
        check("rst_a_addr_err",  32'(bus_a.addr_err),  32'h0);
        check("rst_a_init_busy", 32'(bus_a.init_busy), 32'h1);
        check("rst_b_rd_valid",  32'(bus_b.rd_valid),  32'h0);
        check("rst_b_rd_data",   bus_b.rd_data,        32'h0);
        check("rst_b_addr_err",  32'(bus_b.addr_err),  32'h0);
        check("rst_b_init_busy", 32'(bus_b.init_busy), 32'h1);
        init_left = DEP;
        held_a    = '0;
        pv_valid  = 1'b0;
        pv_err    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [4:0] wa, ra;

        tbl[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,         4'h0, 1'b1, 5'd5,  1'b1, INIT,          1'b0};
        tbl[1]  = '{1'b1, 1'b1, 5'd0,  32'h0000_0007, 4'hF, 1'b0, 5'd0,  1'b0, INIT,          1'b0};
        tbl[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,         4'h0, 1'b1, 5'd0,  1'b1, 32'h0000_0007, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 5'd1,  32'hAABB_CCDD, 4'hF, 1'b0, 5'd0,  1'b0, 32'h0000_0007, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 5'd1,  32'h1122_3344, 4'h5, 1'b0, 5'd0,  1'b0, 32'h0000_0007, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 5'd0,  32'h0,         4'h0, 1'b1, 5'd1,  1'b1, 32'hAA22_CC44, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 5'd3,  32'h1111_115A, 4'h1, 1'b1, 5'd3,  1'b1, 32'hC3C3_A55A, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 5'd25, 32'hFFFF_FFFF, 4'hF, 1'b0, 5'd0,  1'b0, 32'hC3C3_A55A, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 5'd0,  32'h0,         4'h0, 1'b1, 5'd25, 1'b1, 32'h0,         1'b1};
        tbl[9]  = '{1'b1, 1'b0, 5'd0,  32'h0,         4'h0, 1'b1, 5'd19, 1'b1, INIT,          1'b0};
        tbl[10] = '{1'b0, 1'b1, 5'd2,  32'h1234_5678, 4'hF, 1'b1, 5'd2,  1'b0, INIT,          1'b0};
        tbl[11] = '{1'b1, 1'b0, 5'd0,  32'h0,         4'h0, 1'b1, 5'd2,  1'b1, INIT,          1'b0};
        tbl[12] = '{1'b1, 1'b1, 5'd4,  32'hFFFF_FFFF, 4'h0, 1'b0, 5'd0,  1'b0, INIT,          1'b0};
        tbl[13] = '{1'b1, 1'b0, 5'd0,  32'h0,         4'h0, 1'b1, 5'd4,  1'b1, INIT,          1'b0};
        tbl[14] = '{1'b1, 1'b1, 5'd20, 32'h5555_5555, 4'hF, 1'b1, 5'd20, 1'b1, 32'h0,         1'b1};
        tbl[15] = '{1'b1, 1'b0, 5'd0,  32'h0,         4'h0, 1'b0, 5'd0,  1'b0, 32'h0,         1'b0};

        rst_n         = 1'b1;
        bus_a.cs      = 1'b0;
        bus_a.wr_en   = 1'b0;
        bus_a.wr_addr = '0;
        bus_a.wr_data = '0;
        bus_a.wr_be   = '0;
        bus_a.rd_en   = 1'b0;
        bus_a.rd_addr = '0;
`ifdef RAM_PARITY_EN
        bus_a.par_inject = 1'b0;
`endif
        for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
        #7;
        do_reset();

        // A reset partway through the clear restarts the full sequence
        for (int i = 0; i < 7; i++) idle();
        do_reset();
        n = 0;
        while (bus_a.init_busy && n < 100) begin
            idle();
            n++;
        end
        check("init_busy_cycles", 32'(n), 32'(DEP));

        // Directed vectors with hand-computed RD_LAT=1 results
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].cs, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].ra);
            check($sformatf("vec%0d_valid", i), 32'(bus_a.rd_valid), 32'(tbl[i].ev));
            check($sformatf("vec%0d_data", i),  bus_a.rd_data,       tbl[i].ed);
            check($sformatf("vec%0d_err", i),   32'(bus_a.addr_err), 32'(tbl[i].ee));
        end

        // Reset in the middle of a read burst flushes both pipelines
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd1);
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3);
        do_reset();

        // Randomized traffic, starting while the clear is still running
        for (int i = 0; i < 400; i++) begin
            ra = 5'($urandom_range(0, 31));
            wa = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 9) != 0), 1'($urandom), wa, $urandom,
                 4'($urandom), 1'($urandom), ra);
        end

`ifdef RAM_PARITY_EN
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd7);
        check("par_clean", 32'(bus_a.rd_par_err), 32'h0);
        bus_a.par_inject = 1'b1;
        step(1'b1, 1'b1, 5'd6, 32'h0F0F_1234, 4'hF, 1'b0, 5'd0);
        bus_a.par_inject = 1'b0;
        step(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd6);
        check("par_inject_a", 32'(bus_a.rd_par_err), 32'h1);
        idle();
        check("par_inject_b", 32'(bus_b.rd_par_err), 32'h1);
`endif

        idle();
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
